// File: rtl/rr_arb8_pkg.sv
// Shared constants, FSM encoding and the round-robin search for the eight-way arbiter.
package rr_arb8_pkg;

   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic {IDLE, GRANT} state_t;

   // Walks offsets from the far end back toward ptr so the nearest set bit wins.
   function automatic logic [IDX_W-1:0] next_winner(input logic [NUM_REQ-1:0] req,
                                                    input logic [IDX_W-1:0]   ptr);
      logic [IDX_W-1:0] win;
      logic [IDX_W-1:0] idx;
      win = ptr;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         idx = ptr + IDX_W'(i);
         if (req[idx]) win = idx;
      end
      return win;
   endfunction

endpackage

// File: rtl/rr_arb8_sel_dec.sv
// One-hot select decode for the shared resource; the only logic between flops and outputs.
module sel_dec3to8
   import rr_arb8_pkg::*;
(
   input  logic [IDX_W-1:0]   code,
   input  logic               en,
   output logic [NUM_REQ-1:0] onehot
);

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
      assign onehot[k] = en && (code == IDX_W'(k));
   end

endmodule

// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter with break-before-make handover and a hold-time limit.
module rr_arb8
   import rr_arb8_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_code,
   output logic               gnt_valid,
   output logic               timeout
);

   localparam int HCW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
   localparam logic [HCW-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : HCW'(HOLD_MAX - 1);

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic [HCW-1:0]     hold_cnt;

   logic [NUM_REQ-1:0] owner_bit;
   logic               others_pend;
   logic               rel_done, rel_drop, rel_hold, release_now;
   logic [IDX_W-1:0]   winner;

   assign owner_bit   = NUM_REQ'(1) << gnt_code;
   assign others_pend = |(req & ~owner_bit);
   assign winner      = next_winner(req, ptr);

   assign rel_done    = done;
   assign rel_drop    = !req[gnt_code];
   assign rel_hold    = (HOLD_MAX != 0) && (hold_cnt == HOLD_LAST) && others_pend;
   assign release_now = rel_done || rel_drop || rel_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         gnt_code  <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  state     <= GRANT;
                  gnt_code  <= winner;
                  gnt_valid <= 1'b1;
                  hold_cnt  <= '0;
                  ptr       <= winner + 1'b1;
               end
            end
            GRANT: begin
               if (release_now) begin
                  // gnt_code is kept so the last owner stays visible after release.
                  state     <= IDLE;
                  gnt_valid <= 1'b0;
                  timeout   <= rel_hold && !rel_done && !rel_drop;
               end else if (hold_cnt != HOLD_LAST) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               gnt_valid <= 1'b0;
            end
         endcase
      end
   end

   sel_dec3to8 u_dec (
      .code   (gnt_code),
      .en     (gnt_valid),
      .onehot (gnt)
   );

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8 with HOLD_MAX=4; expected values are hand-derived per step.
module tb_rr_arb8;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_code;
   logic       gnt_valid;
   logic       timeout;

   int n_chk;
   int n_err;

   rr_arb8 #(.HOLD_MAX(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_code  (gnt_code),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_grant(input string tag, input logic [2:0] code);
      chk({tag, "_vld"},  32'(gnt_valid), 32'd1);
      chk({tag, "_code"}, 32'(gnt_code),  32'(code));
      chk({tag, "_gnt"},  32'(gnt),       32'(8'h01 << code));
   endtask

   task automatic chk_idle(input string tag, input logic to_exp);
      chk({tag, "_vld"}, 32'(gnt_valid), 32'd0);
      chk({tag, "_gnt"}, 32'(gnt),       32'd0);
      chk({tag, "_to"},  32'(timeout),   32'(to_exp));
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      req   = 8'h00;
      done  = 1'b0;
      #12;
      chk_idle("rst", 1'b0);
      chk("rst_code", 32'(gnt_code), 32'd0);
      rst_n = 1'b1;
      tick();

      // single requester, ptr starts at 0
      req = 8'h08;
      tick(); chk_grant("single", 3'd3);
      done = 1'b1;
      tick(); done = 1'b0;
      chk_idle("single_rel", 1'b0);
      chk("single_keep_code", 32'(gnt_code), 32'd3);
      req = 8'h18;                      // ptr=4 must favour bit 4 over bit 3
      tick(); chk_grant("ptr4", 3'd4);
      req = 8'h00;                      // request drop with done=0
      tick(); chk_idle("drop_rel", 1'b0);

      // priority from pointer: get ptr to 6 via owner 5
      req = 8'h20;
      tick(); chk_grant("own5", 3'd5);
      req = 8'h00;
      tick();
      req = 8'h41;
      tick(); chk_grant("prio6", 3'd6);
      done = 1'b1;
      tick(); done = 1'b0;
      chk_idle("prio_gap", 1'b0);
      tick(); chk_grant("prio_wrap", 3'd0);
      req = 8'h00;
      tick();

      // rotation 0..7,0: first bring ptr back to 0 via owner 7
      req = 8'h80;
      tick(); chk_grant("own7a", 3'd7);
      req = 8'h00;
      tick();
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         tick(); chk_grant($sformatf("rot%0d", k), 3'(k % 8));
         tick(); chk($sformatf("rot%0d_hold", k), 32'(gnt_valid), 32'd1);
         done = 1'b1;
         tick(); done = 1'b0;
         chk_idle($sformatf("rot%0d_gap", k), 1'b0);
      end
      req = 8'h00;
      tick();

      // hold limit with a competitor: ptr back to 0 first
      req = 8'h80;
      tick(); chk_grant("own7b", 3'd7);
      req = 8'h00;
      tick();
      req = 8'h03;
      tick(); chk_grant("hold_g", 3'd0);
      for (int k = 1; k < 4; k++) begin
         tick();
         chk($sformatf("hold_c%0d_vld", k), 32'(gnt_valid), 32'd1);
         chk($sformatf("hold_c%0d_to", k),  32'(timeout),   32'd0);
      end
      tick(); chk_idle("hold_exp", 1'b1);
      chk("hold_exp_code", 32'(gnt_code), 32'd0);
      tick(); chk_grant("hold_next", 3'd1);
      chk("hold_next_to", 32'(timeout), 32'd0);
      req = 8'h00;
      tick(); chk_idle("hold_next_rel", 1'b0);

      // lone requester past the limit keeps the grant; ptr=2 so bit 0 wins
      req = 8'h01;
      tick(); chk_grant("lone_g", 3'd0);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk($sformatf("lone%0d_vld", k), 32'(gnt_valid), 32'd1);
         chk($sformatf("lone%0d_to", k),  32'(timeout),   32'd0);
      end
      req = 8'h03;                      // competitor appears while saturated
      tick(); chk_idle("lone_force", 1'b1);
      req = 8'h00;
      tick(); chk_idle("lone_after", 1'b0);

      // done coinciding with expiry, ptr=1 so owner 1
      req = 8'h03;
      tick(); chk_grant("coin_g", 3'd1);
      tick(); tick(); tick();
      chk("coin_pre_vld", 32'(gnt_valid), 32'd1);
      done = 1'b1;
      tick(); done = 1'b0;
      chk_idle("coin_rel", 1'b0);
      req = 8'h00;
      tick();

      // asynchronous reset mid-grant of owner 5
      req = 8'h20;
      tick(); chk_grant("mid_g", 3'd5);
      #2 rst_n = 1'b0;
      #1;
      chk_idle("mid_rst", 1'b0);
      chk("mid_rst_code", 32'(gnt_code), 32'd0);
      req = 8'h00;
      #2 rst_n = 1'b1;
      req = 8'hA0;                      // ptr=0 picks 5; a stale ptr=6 would pick 7
      tick(); chk_grant("post_rst", 3'd5);
      req = 8'h00;
      tick();
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      req = 8'h01;
      tick(); chk_grant("post_rst0", 3'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
